// File: rtl/fv_bank_router_if.sv
// Bundle of the FIFO-side and bank-side signals of the FV bank router.
// The master modport is the router; the slave modport is its surroundings
// (request FIFO plus the per-bank FV controllers).
interface fv_bank_router_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int TAG_W     = 4
);
  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int LOC_W      = ADDR_W - BANK_SEL_W;

  logic                       fifo_empty;
  logic                       fifo_rinc;
  logic                       fifo_valid;
  logic [ADDR_W-1:0]          fifo_addr;
  logic [TAG_W-1:0]           fifo_pe_tag;
  logic [NUM_BANKS-1:0]       bank_busy;
  logic [NUM_BANKS-1:0]       bank_valid;
  logic [NUM_BANKS*LOC_W-1:0] bank_addr;
  logic [NUM_BANKS*TAG_W-1:0] bank_pe_tag;
  logic                       router_idle;

  modport master (
    input  fifo_empty, fifo_valid, fifo_addr, fifo_pe_tag, bank_busy,
    output fifo_rinc, bank_valid, bank_addr, bank_pe_tag, router_idle
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_addr, fifo_pe_tag, bank_busy,
    input  fifo_rinc, bank_valid, bank_addr, bank_pe_tag, router_idle
  );
endinterface

// File: rtl/fv_bank_router.sv
// FV bank router: pulls read requests from the FV request FIFO one at a
// time, routes each to a per-bank holding slot, and lets every slot issue
// to its bank independently. A request whose slot is still occupied waits
// in a single hold register, which stalls further FIFO reads until the
// slot frees; requests to other banks already in their slots keep issuing.
module fv_bank_router #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_SEL_W = $clog2(NUM_BANKS),
  parameter int ADDR_W     = 10,
  parameter int TAG_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  fv_bank_router_if.master  bus
);
  localparam int LOC_W = ADDR_W - BANK_SEL_W;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t                      state_q, state_d;
  logic                        rinc_q, rinc_d;

  logic [NUM_BANKS-1:0]        slotValid_q;
  logic [LOC_W-1:0]            slotAddr_q [NUM_BANKS];
  logic [TAG_W-1:0]            slotTag_q  [NUM_BANKS];

  logic [BANK_SEL_W-1:0]       holdBank_q;
  logic [LOC_W-1:0]            holdAddr_q;
  logic [TAG_W-1:0]            holdTag_q;

  logic [NUM_BANKS-1:0]        bankValid_q;
  logic [NUM_BANKS*LOC_W-1:0]  bankAddr_q;
  logic [NUM_BANKS*TAG_W-1:0]  bankTag_q;

  logic [BANK_SEL_W-1:0]       reqBank;
  logic [LOC_W-1:0]            reqAddr;
  logic [NUM_BANKS-1:0]        issue;
  logic [NUM_BANKS-1:0]        slotFree;
  logic                        fifoAccept;
  logic                        fifoHold;
  logic                        holdRelease;

  logic                        slotWe;
  logic [BANK_SEL_W-1:0]       wrBank;
  logic [LOC_W-1:0]            wrAddr;
  logic [TAG_W-1:0]            wrTag;
  logic                        holdLoad;
  logic                        routerIdle;

  // A slot counts as free if empty or issuing at this edge, so it can be
  // refilled at the same edge it drains.
  assign reqBank     = bus.fifo_addr[ADDR_W-1 -: BANK_SEL_W];
  assign reqAddr     = bus.fifo_addr[LOC_W-1:0];
  assign issue       = slotValid_q & ~bus.bank_busy;
  assign slotFree    = ~slotValid_q | issue;
  assign fifoAccept  = (state_q == WAIT) && bus.fifo_valid && slotFree[reqBank];
  assign fifoHold    = (state_q == WAIT) && bus.fifo_valid && !slotFree[reqBank];
  assign holdRelease = (state_q == HOLD) && slotFree[holdBank_q];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: read, wait for data, or park on an occupied slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!bus.fifo_empty) state_d = WAIT;
      WAIT: begin
        if (fifoHold)        state_d = HOLD;
        else if (fifoAccept) state_d = bus.fifo_empty ? IDLE : WAIT;
      end
      HOLD: if (holdRelease) state_d = bus.fifo_empty ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // Output/control logic: next FIFO read, slot write source, hold capture.
  always_comb begin
    rinc_d     = 1'b0;
    slotWe     = 1'b0;
    wrBank     = reqBank;
    wrAddr     = reqAddr;
    wrTag      = bus.fifo_pe_tag;
    holdLoad   = 1'b0;
    routerIdle = 1'b0;
    unique case (state_q)
      IDLE: begin
        rinc_d     = !bus.fifo_empty;
        routerIdle = ~|slotValid_q;
      end
      WAIT: begin
        if (fifoAccept) begin
          slotWe = 1'b1;
          rinc_d = !bus.fifo_empty;
        end
        holdLoad = fifoHold;
      end
      HOLD: begin
        wrBank = holdBank_q;
        wrAddr = holdAddr_q;
        wrTag  = holdTag_q;
        if (holdRelease) begin
          slotWe = 1'b1;
          rinc_d = !bus.fifo_empty;
        end
      end
      default: ;
    endcase
  end

  // FIFO read strobe and hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rinc_q     <= 1'b0;
      holdBank_q <= '0;
      holdAddr_q <= '0;
      holdTag_q  <= '0;
    end else begin
      rinc_q <= rinc_d;
      if (holdLoad) begin
        holdBank_q <= reqBank;
        holdAddr_q <= reqAddr;
        holdTag_q  <= bus.fifo_pe_tag;
      end
    end
  end

  // Per-bank holding slots: a write wins over the issue-clear of the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slotValid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        slotAddr_q[b] <= '0;
        slotTag_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (slotWe && (wrBank == BANK_SEL_W'(b))) begin
          slotValid_q[b] <= 1'b1;
          slotAddr_q[b]  <= wrAddr;
          slotTag_q[b]   <= wrTag;
        end else if (issue[b]) begin
          slotValid_q[b] <= 1'b0;
        end
      end
    end
  end

  // Registered bank issue strobes; idle banks present zero address and tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bankValid_q <= '0;
      bankAddr_q  <= '0;
      bankTag_q   <= '0;
    end else begin
      bankValid_q <= issue;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bankAddr_q[b*LOC_W +: LOC_W] <= issue[b] ? slotAddr_q[b] : '0;
        bankTag_q[b*TAG_W +: TAG_W]  <= issue[b] ? slotTag_q[b]  : '0;
      end
    end
  end

  assign bus.fifo_rinc   = rinc_q;
  assign bus.bank_valid  = bankValid_q;
  assign bus.bank_addr   = bankAddr_q;
  assign bus.bank_pe_tag = bankTag_q;
  assign bus.router_idle = routerIdle;
endmodule

// File: tb/tb_fv_bank_router.sv
// Testbench for fv_bank_router: a behavioural request FIFO feeds the router,
// per-bank scoreboard queues hold the expected bank-local address and tag of
// every pushed request, and a negedge monitor pops and compares each issue.
module tb_fv_bank_router;
  localparam int NB = 4;
  localparam int AW = 10;
  localparam int TW = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset;

  fv_bank_router_if #(.NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW)) bus ();

  fv_bank_router #(.NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW+TW-1:0] fifoQ [$];
  int               pushCount = 0;
  int               popCount  = 0;
  logic             rincSeen;
  logic [AW+TW-1:0] entry;

  logic [LW+TW-1:0] expQ [NB][$];
  int               pulseCount [NB];
  int               lastPulse  [NB];
  int               prevPulse  [NB];
  int               rincCount = 0;
  int               cycle = 0;

  int               baseRinc;
  int               basePulse [NB];

  assign bus.fifo_empty = (pushCount == popCount);

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Request FIFO model: a read strobe seen at an edge yields data next cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifoQ.delete();
      popCount        = pushCount;
      bus.fifo_valid  = 1'b0;
      bus.fifo_addr   = '0;
      bus.fifo_pe_tag = '0;
    end else begin
      rincSeen = bus.fifo_rinc;
      #1;
      if (rincSeen) checkOutput("rinc_on_empty", (fifoQ.size() != 0), 1);
      if (rincSeen && fifoQ.size() != 0) begin
        entry           = fifoQ.pop_front();
        popCount++;
        bus.fifo_valid  = 1'b1;
        bus.fifo_addr   = entry[AW+TW-1:TW];
        bus.fifo_pe_tag = entry[TW-1:0];
      end else begin
        bus.fifo_valid  = 1'b0;
      end
    end
  end

  // Issue monitor: every strobe must match the head of its bank's queue.
  always @(negedge clk) begin
    cycle++;
    if (!reset) begin
      if (bus.fifo_rinc) rincCount++;
      for (int b = 0; b < NB; b++) begin
        if (bus.bank_valid[b]) begin
          pulseCount[b]++;
          prevPulse[b] = lastPulse[b];
          lastPulse[b] = cycle;
          if (expQ[b].size() == 0) begin
            checkOutput("unexpected_issue", b, 32'hFF);
          end else begin
            logic [LW+TW-1:0] e;
            e = expQ[b].pop_front();
            checkOutput("bank_addr", bus.bank_addr[b*LW +: LW], e[LW+TW-1:TW]);
            checkOutput("bank_tag", bus.bank_pe_tag[b*TW +: TW], e[TW-1:0]);
          end
        end else begin
          checkOutput("idle_slice_zero",
                      {bus.bank_addr[b*LW +: LW], bus.bank_pe_tag[b*TW +: TW]}, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    fifoQ.push_back({addr, tag});
    pushCount++;
    expQ[addr[AW-1:AW-2]].push_back({addr[LW-1:0], tag});
  endtask

  task automatic snap();
    baseRinc = rincCount;
    for (int b = 0; b < NB; b++) basePulse[b] = pulseCount[b];
  endtask

  task automatic waitDrain(input int limit);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      tick(1);
      n++;
      done = bus.router_idle && bus.fifo_empty && (bus.bank_valid == '0) &&
             (expQ[0].size() == 0) && (expQ[1].size() == 0) &&
             (expQ[2].size() == 0) && (expQ[3].size() == 0);
    end
    checkOutput("drain_timeout", done, 1);
  endtask

  initial begin
    int vcount;
    int n;
    bit seen;
    for (int b = 0; b < NB; b++) begin
      pulseCount[b] = 0;
      lastPulse[b]  = 0;
      prevPulse[b]  = 0;
    end
    reset         = 1'b1;
    bus.bank_busy = '0;
    tick(3);
    checkOutput("reset_rinc", bus.fifo_rinc, 0);
    checkOutput("reset_bank_valid", bus.bank_valid, 0);
    checkOutput("reset_bank_addr", bus.bank_addr, 0);
    checkOutput("reset_idle", bus.router_idle, 1);
    reset = 1'b0;
    tick(3);
    checkOutput("post_reset_idle", bus.router_idle, 1);
    checkOutput("post_reset_rinc_count", rincCount, 0);

    // Single request to bank 2.
    snap();
    applyStimulus(10'h2A5, 4'h7);
    waitDrain(40);
    checkOutput("single_b2_pulses", pulseCount[2] - basePulse[2], 1);
    checkOutput("single_other_pulses",
                pulseCount[0] + pulseCount[1] + pulseCount[3]
                - basePulse[0] - basePulse[1] - basePulse[3], 0);

    // Streaming across all banks.
    snap();
    for (int b = 0; b < NB; b++) applyStimulus({b[1:0], 8'h10 + 8'(b)}, 4'(b + 1));
    waitDrain(60);
    checkOutput("stream_rinc", rincCount - baseRinc, 4);
    for (int b = 0; b < NB; b++) checkOutput("stream_pulse", pulseCount[b] - basePulse[b], 1);
    for (int b = 1; b < NB; b++) checkOutput("stream_order", lastPulse[b] > lastPulse[b-1], 1);

    // Bank isolation: bank 1 busy, traffic to 1,3,1 then 0 behind the hold.
    snap();
    bus.bank_busy = 4'b0010;
    applyStimulus(10'h140, 4'h1);
    applyStimulus(10'h3C3, 4'h2);
    applyStimulus(10'h141, 4'h3);
    applyStimulus(10'h022, 4'h4);
    tick(25);
    checkOutput("iso_b3_issued", pulseCount[3] - basePulse[3], 1);
    checkOutput("iso_b1_blocked", pulseCount[1] - basePulse[1], 0);
    checkOutput("iso_hold_no_rinc", rincCount - baseRinc, 3);
    checkOutput("iso_b0_waiting", pulseCount[0] - basePulse[0], 0);
    checkOutput("iso_not_idle", bus.router_idle, 0);
    bus.bank_busy = '0;
    waitDrain(60);
    checkOutput("iso_b1_pulses", pulseCount[1] - basePulse[1], 2);
    checkOutput("iso_b0_pulses", pulseCount[0] - basePulse[0], 1);
    checkOutput("iso_rinc_total", rincCount - baseRinc, 4);

    // Same-edge reuse: release bank 0 in the cycle the second request's data is valid.
    snap();
    bus.bank_busy = 4'b0001;
    applyStimulus(10'h0A0, 4'h5);
    applyStimulus(10'h0A1, 4'h6);
    vcount = 0;
    n      = 0;
    while (vcount < 2 && n < 40) begin
      tick(1);
      n++;
      if (bus.fifo_valid) vcount++;
    end
    checkOutput("reuse_valid_timeout", vcount, 2);
    bus.bank_busy = '0;
    waitDrain(40);
    checkOutput("reuse_pulses", pulseCount[0] - basePulse[0], 2);
    checkOutput("reuse_gap", lastPulse[0] - prevPulse[0], 1);

    // Long stall on bank 2 with a held request and a bank-0 request queued.
    bus.bank_busy = 4'b0100;
    applyStimulus(10'h2B0, 4'h8);
    applyStimulus(10'h2B1, 4'h9);
    applyStimulus(10'h0B2, 4'hA);
    tick(15);
    snap();
    tick(50);
    checkOutput("stall_no_rinc", rincCount - baseRinc, 0);
    checkOutput("stall_b2_quiet", pulseCount[2] - basePulse[2], 0);
    checkOutput("stall_b0_quiet", pulseCount[0] - basePulse[0], 0);
    checkOutput("stall_not_idle", bus.router_idle, 0);
    bus.bank_busy = '0;
    waitDrain(40);
    checkOutput("stall_b2_pulses", pulseCount[2] - basePulse[2], 2);
    checkOutput("stall_b0_pulse", pulseCount[0] - basePulse[0], 1);
    checkOutput("stall_rinc_resume", rincCount - baseRinc, 1);

    // Asynchronous reset while a FIFO read is in flight.
    applyStimulus(10'h155, 4'hB);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      tick(1);
      n++;
      seen = bus.fifo_rinc;
    end
    checkOutput("rst_rinc_seen", seen, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_rinc", bus.fifo_rinc, 0);
    checkOutput("rst_async_valid", bus.bank_valid, 0);
    checkOutput("rst_async_idle", bus.router_idle, 1);
    for (int b = 0; b < NB; b++) expQ[b].delete();
    tick(2);
    reset = 1'b0;
    snap();
    tick(10);
    checkOutput("rst_no_rinc", rincCount - baseRinc, 0);
    checkOutput("rst_dropped", pulseCount[1] - basePulse[1], 0);
    checkOutput("rst_idle", bus.router_idle, 1);

    // Random traffic with random busy patterns.
    snap();
    for (int i = 0; i < 16; i++)
      applyStimulus(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 40; i++) begin
      bus.bank_busy = 4'($urandom_range(0, 15));
      tick(1);
    end
    bus.bank_busy = '0;
    waitDrain(200);
    checkOutput("rand_rinc", rincCount - baseRinc, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
